query_rx: RTL

- Tag-side Query command framer that sits directly upstream of the CRC-5 generator/checker.
- Consumes decoded reader-to-tag bits from the PIE decoder as one-cycle strobes on the system clock.
- Checks the 4-bit Query opcode, shifts all 22 bits through a CRC-5 register, and extracts the Query fields.
- Emits a one-cycle result pulse with a CRC verdict to the tag control FSM.

---
 rtl/rfid_pkg.sv | 36 +++
 rtl/crc5_en.sv | 34 +++
 rtl/query_rx.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rfid_pkg.sv
// Shared definitions for the tag-side reader-command receive path:
// opcodes, CRC-5 constants, Query field layout and the framer state type.
package rfid_pkg;

   localparam logic [3:0] QUERY_CMD    = 4'b1000;
   localparam logic [4:0] CRC5_PRESET  = 5'b01001;
   localparam logic [4:0] CRC5_RESIDUE = 5'b00000;

   localparam int unsigned DR_W      = 1;
   localparam int unsigned M_W       = 2;
   localparam int unsigned TREXT_W   = 1;
   localparam int unsigned SEL_W     = 2;
   localparam int unsigned SESSION_W = 2;
   localparam int unsigned TARGET_W  = 1;
   localparam int unsigned Q_W       = 4;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StBody,
      StCrc,
      StSkip
   } rx_state_e;

   // Packed in transmission order, so the first body bit lands in dr.
   typedef struct packed {
      logic [DR_W-1:0]      dr;
      logic [M_W-1:0]       m;
      logic [TREXT_W-1:0]   trext;
      logic [SEL_W-1:0]     sel;
      logic [SESSION_W-1:0] session;
      logic [TARGET_W-1:0]  target;
      logic [Q_W-1:0]       q;
   } query_fields_t;

endpackage

// File: rtl/crc5_en.sv
// CRC-5 (x^5 + x^3 + 1) shift register, MSB-first input, with enable and
// synchronous preset; preset takes priority over enable.
module crc5_en
   import rfid_pkg::*;
#(
   parameter logic [4:0] PRESET = CRC5_PRESET
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       preset,
   input  logic       en,
   input  logic       din,
   output logic [4:0] crc
);

   logic       fb;
   logic [4:0] crc_next;

   always_comb begin
      fb       = din ^ crc[4];
      crc_next = {crc[3], crc[2] ^ fb, crc[1], crc[0], fb};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         crc <= PRESET;
      end else if (preset) begin
         crc <= PRESET;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/query_rx.sv
// Query command framer: checks the opcode, runs all frame bits through CRC-5,
// extracts the Query fields and reports a one-cycle result pulse.
module query_rx
   import rfid_pkg::*;
#(
   parameter int unsigned CMD_BITS   = 4,
   parameter int unsigned BODY_BITS  = 13,
   parameter int unsigned CRC_BITS   = 5,
   parameter logic [4:0]  CRC_PRESET = 5'b01001
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       frame_start,
   input  logic       bit_valid,
   input  logic       bit_in,
   output logic       query_valid,
   output logic       crc_ok,
   output logic       cmd_other,
   output logic       dr,
   output logic [1:0] m,
   output logic       trext,
   output logic [1:0] sel,
   output logic [1:0] session,
   output logic       target,
   output logic [3:0] q,
   output logic       busy
);

   localparam int unsigned HEAD_BITS  = CMD_BITS + BODY_BITS;
   localparam int unsigned FRAME_BITS = HEAD_BITS + CRC_BITS;
   localparam logic [4:0]  CMD_LAST   = 5'(CMD_BITS - 1);
   localparam logic [4:0]  BODY_LAST  = 5'(HEAD_BITS - 1);
   localparam logic [4:0]  FRAME_LAST = 5'(FRAME_BITS - 1);

   rx_state_e             state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [HEAD_BITS-1:0]  shreg_q, shreg_d;
   logic [4:0]            crc;
   query_fields_t         fields_q;
   logic                  crc_ok_q;
   logic                  in_frame, accept, cmd_match;
   logic                  query_valid_d, cmd_other_d;

   // A coincident frame_start wins, so the colliding bit is never accepted.
   assign in_frame  = state_q inside {StCmd, StBody, StCrc};
   assign accept    = bit_valid & in_frame & ~frame_start;
   assign cmd_match = ({shreg_q[CMD_BITS-2:0], bit_in} == QUERY_CMD);

   crc5_en #(
      .PRESET (CRC_PRESET)
   ) u_crc5 (
      .clk     (clk),
      .reset_n (reset_n),
      .preset  (frame_start),
      .en      (accept),
      .din     (bit_in),
      .crc     (crc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (frame_start) begin
         state_d = StCmd;
      end else if (accept) begin
         case (state_q)
            StCmd:   if (cnt_q == CMD_LAST)   state_d = cmd_match ? StBody : StSkip;
            StBody:  if (cnt_q == BODY_LAST)  state_d = StCrc;
            StCrc:   if (cnt_q == FRAME_LAST) state_d = StIdle;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      busy          = in_frame;
      cmd_other_d   = accept & (state_q == StCmd) & (cnt_q == CMD_LAST) & ~cmd_match;
      query_valid_d = accept & (state_q == StCrc) & (cnt_q == FRAME_LAST) &
                      (shreg_q[HEAD_BITS-1 -: CMD_BITS] == QUERY_CMD);
   end

   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (frame_start) begin
         cnt_d   = '0;
         shreg_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + 5'd1;
         if (state_q != StCrc) begin
            shreg_d = {shreg_q[HEAD_BITS-2:0], bit_in};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q       <= '0;
         shreg_q     <= '0;
         query_valid <= 1'b0;
         cmd_other   <= 1'b0;
         fields_q    <= '0;
         crc_ok_q    <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shreg_q     <= shreg_d;
         query_valid <= query_valid_d;
         cmd_other   <= cmd_other_d;
         if (query_valid_d) begin
            fields_q <= query_fields_t'(shreg_q[BODY_BITS-1:0]);
         end
         if (query_valid) begin
            crc_ok_q <= (crc == CRC5_RESIDUE);
         end
      end
   end

   // During the pulse the CRC register already holds the post-frame residue.
   assign crc_ok  = query_valid ? (crc == CRC5_RESIDUE) : crc_ok_q;

   assign dr      = fields_q.dr;
   assign m       = fields_q.m;
   assign trext   = fields_q.trext;
   assign sel     = fields_q.sel;
   assign session = fields_q.session;
   assign target  = fields_q.target;
   assign q       = fields_q.q;

endmodule
